prt_slot_store: RTL and testbench
=================================

// Module: prt_slot_store
// PURPOSE
// - Responder side of the PRT method handshake that the MPD drives.
// - Stores packets in NUM_SLOTS slots of up to MAX_BEATS DATA_WIDTH-bit words.
// - Writes allocate the lowest free slot and fill it beat by beat; finish marks the slot VALID.
// - Reads stream a VALID slot back beat by beat; invalidate returns a slot to FREE.
// PARAMETERS
// DATA_WIDTH  32  width of one stored beat
// NUM_SLOTS   16  number of packet slots (power of 2, >=2)
// MAX_BEATS   64  max beats per slot (power of 2); SW=$clog2(NUM_SLOTS), BW=$clog2(MAX_BEATS)
// PORTS
// clk                          in   1           clock, rising edge
// rst                          in   1           async reset, active-high
// EN_start_writing_prt_entry   in   1           allocate slot, open write
// RDY_start_writing_prt_entry  out  1           free slot exists && no write open
// start_writing_prt_entry      out  SW          slot being allocated (valid when RDY)
// EN_write_prt_entry           in   1           store one beat
// RDY_write_prt_entry          out  1           write open && wr_cnt<MAX_BEATS
// write_prt_entry_data         in   DATA_WIDTH  beat data
// EN_finish_writing_prt_entry  in   1           close write
// RDY_finish_writing_prt_entry out  1           write open
// EN_invalidate_prt_entry      in   1           free a slot
// RDY_invalidate_prt_entry     out  1           1 out of reset
// invalidate_prt_entry_slot    in   SW          slot to free
// EN_start_reading_prt_entry   in   1           open read of slot
// RDY_start_reading_prt_entry  out  1           no read open
// start_reading_prt_entry_slot in   SW          slot to read
// EN_read_prt_entry            in   1           consume current beat
// RDY_read_prt_entry           out  1           read open
// read_prt_entry               out  DATA_WIDTH  current beat, combinational from storage
// read_prt_entry_last          out  1           current beat is final beat of slot
// read_prt_entry_err           out  1           1-cycle pulse: start_reading on non-VALID slot
// is_prt_slot_free             out  1           any slot FREE
// RDY_is_prt_slot_free         out  1           1 out of reset
// BEHAVIOUR
// - Per-slot state FREE/WRITING/VALID/READING plus BW+1-bit length. Write FSM W_IDLE/W_OPEN; read FSM R_IDLE/R_OPEN.
// - Reset: all slots FREE, both FSMs idle, counters 0, err 0. All RDY_* are 0 while rst is high.
// - start_writing: combinational priority encoder picks the lowest-index FREE slot. EN sets that slot WRITING, wr_cnt=0, W_OPEN next cycle.
// - write: mem[slot][wr_cnt]<=data, wr_cnt++, one beat per cycle. Beat MAX_BEATS+1 is blocked because RDY drops.
// - finish: len=wr_cnt. Slot becomes VALID if len>0, FREE if len==0. Go to W_IDLE. EN_write in the same cycle as EN_finish is stored first and counted.
// - start_reading: a VALID slot goes READING with rd_ptr=0 and R_OPEN. Otherwise the request is dropped, the read FSM stays idle and err pulses.
// - read: rd_ptr++ per EN. On EN with last=1 the slot returns to VALID and the FSM goes to R_IDLE. last=(rd_ptr==len-1).
// - invalidate: VALID->FREE. READING->FREE and the read FSM aborts to R_IDLE. FREE/WRITING: ignored.
// - The same-cycle invalidate of the slot whose last beat is being read resolves to FREE.
// - Write and read FSMs run concurrently on different slots. A slot in WRITING is never readable.
// - EN asserted while its RDY is 0 is ignored (protocol violation; the bench asserts on it).
// - rst mid-transaction: the transaction is lost, all slots FREE.
// CONFIGURATION
// - PRT_AUTO_INVALIDATE_EN defined: reading the last beat frees the slot (READING->FREE).
// - Not defined: the slot returns to VALID and needs an explicit invalidate; re-reads allowed.
// STRUCTURE
// - prt_pkg: slot_state_e {FREE,WRITING,VALID,READING}, wr_state_e, rd_state_e, PRT_SW/PRT_BW localparam functions.
// - Sub-module prt_free_encoder: NUM_SLOTS-bit free vector -> lowest index + any_free.
// - Storage: NUM_SLOTS*MAX_BEATS register/LUTRAM array, one write port, one async read port.
// TESTING
// 1. Reset release, start_write, 3 beats A,B,C, finish -> slot 0 VALID len 3; next start_writing_prt_entry=1.
// 2. Read slot 0 -> beats A,B,C; last=1 on C; then RDY_start_reading=1.
// 3. Fill all 16 slots -> RDY_start_writing=0, is_prt_slot_free=0; invalidate slot 5 -> next alloc=5.
// 4. start_reading on a FREE slot -> err pulse 1 cycle, RDY_read stays 0.
// 5. 64 beats -> RDY_write=0 after the 64th; finish with 0 beats -> slot FREE.
// 6. Invalidate mid-read after 1 of 3 beats -> read aborts, slot FREE. With PRT_AUTO_INVALIDATE_EN, a full read frees the slot.

Source files
------------

// File: rtl/prt_pkg.sv
// rtl/prt_pkg.sv - shared types and width helpers for the PRT slot store
package prt_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        VALID   = 2'd2,
        READING = 2'd3
    } slot_state_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_OPEN = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_OPEN = 1'b1
    } rd_state_e;

    // Slot index width for a given slot count
    function automatic int prt_sw(input int num_slots);
        return $clog2(num_slots);
    endfunction

    // Beat index width for a given slot depth
    function automatic int prt_bw(input int max_beats);
        return $clog2(max_beats);
    endfunction

endpackage

// File: rtl/prt_slot_store_if.sv
// rtl/prt_slot_store_if.sv - PRT method handshake bundle between MPD (master) and slot store (slave)
interface prt_slot_store_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 16
);
    import prt_pkg::*;
    localparam int SW = prt_sw(NUM_SLOTS);

    logic                  EN_start_writing_prt_entry;
    logic                  RDY_start_writing_prt_entry;
    logic [SW-1:0]         start_writing_prt_entry;
    logic                  EN_write_prt_entry;
    logic                  RDY_write_prt_entry;
    logic [DATA_WIDTH-1:0] write_prt_entry_data;
    logic                  EN_finish_writing_prt_entry;
    logic                  RDY_finish_writing_prt_entry;
    logic                  EN_invalidate_prt_entry;
    logic                  RDY_invalidate_prt_entry;
    logic [SW-1:0]         invalidate_prt_entry_slot;
    logic                  EN_start_reading_prt_entry;
    logic                  RDY_start_reading_prt_entry;
    logic [SW-1:0]         start_reading_prt_entry_slot;
    logic                  EN_read_prt_entry;
    logic                  RDY_read_prt_entry;
    logic [DATA_WIDTH-1:0] read_prt_entry;
    logic                  read_prt_entry_last;
    logic                  read_prt_entry_err;
    logic                  is_prt_slot_free;
    logic                  RDY_is_prt_slot_free;

    modport master (
        output EN_start_writing_prt_entry, EN_write_prt_entry, write_prt_entry_data,
               EN_finish_writing_prt_entry, EN_invalidate_prt_entry, invalidate_prt_entry_slot,
               EN_start_reading_prt_entry, start_reading_prt_entry_slot, EN_read_prt_entry,
        input  RDY_start_writing_prt_entry, start_writing_prt_entry, RDY_write_prt_entry,
               RDY_finish_writing_prt_entry, RDY_invalidate_prt_entry, RDY_start_reading_prt_entry,
               RDY_read_prt_entry, read_prt_entry, read_prt_entry_last, read_prt_entry_err,
               is_prt_slot_free, RDY_is_prt_slot_free
    );

    modport slave (
        input  EN_start_writing_prt_entry, EN_write_prt_entry, write_prt_entry_data,
               EN_finish_writing_prt_entry, EN_invalidate_prt_entry, invalidate_prt_entry_slot,
               EN_start_reading_prt_entry, start_reading_prt_entry_slot, EN_read_prt_entry,
        output RDY_start_writing_prt_entry, start_writing_prt_entry, RDY_write_prt_entry,
               RDY_finish_writing_prt_entry, RDY_invalidate_prt_entry, RDY_start_reading_prt_entry,
               RDY_read_prt_entry, read_prt_entry, read_prt_entry_last, read_prt_entry_err,
               is_prt_slot_free, RDY_is_prt_slot_free
    );

endinterface

// File: rtl/prt_free_encoder.sv
// rtl/prt_free_encoder.sv - lowest-index free slot priority encoder
module prt_free_encoder
    import prt_pkg::*;
#(
    parameter int NUM_SLOTS = 16
) (
    input  logic [NUM_SLOTS-1:0]        free_vec_i,
    output logic [prt_sw(NUM_SLOTS)-1:0] idx_o,
    output logic                        any_free_o
);
    localparam int SW = prt_sw(NUM_SLOTS);

    // Scan from the top so the lowest free index is the last one to win
    always_comb begin
        idx_o      = '0;
        any_free_o = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_vec_i[i]) begin
                idx_o      = SW'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prt_slot_store.sv
// rtl/prt_slot_store.sv - PRT packet slot store; PRT_AUTO_INVALIDATE_EN frees a slot once fully read
module prt_slot_store
    import prt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 16,
    parameter int MAX_BEATS  = 64
) (
    input  logic           clk,
    input  logic           rst,
    prt_slot_store_if.slave bus
);
    localparam int SW = prt_sw(NUM_SLOTS);
    localparam int BW = prt_bw(MAX_BEATS);

    slot_state_e           slot_q [NUM_SLOTS];
    logic [BW:0]           len_q  [NUM_SLOTS];
    wr_state_e             wr_state_q;
    logic [SW-1:0]         wr_slot_q;
    logic [BW:0]           wr_cnt_q;
    rd_state_e             rd_state_q;
    logic [SW-1:0]         rd_slot_q;
    logic [BW-1:0]         rd_ptr_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS*MAX_BEATS];

    logic [NUM_SLOTS-1:0]  free_vec;
    logic [SW-1:0]         alloc_idx;
    logic                  any_free;

    // Flag every FREE slot for the allocator
    always_comb begin
        free_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) free_vec[i] = (slot_q[i] == FREE);
    end

    prt_free_encoder #(.NUM_SLOTS(NUM_SLOTS)) u_free_encoder (
        .free_vec_i (free_vec),
        .idx_o      (alloc_idx),
        .any_free_o (any_free)
    );

    // Every ready is forced low while reset is held
    logic rdy_start_write, rdy_write, rdy_finish, rdy_start_read, rdy_read;
    assign rdy_start_write = !rst && any_free && (wr_state_q == W_IDLE);
    assign rdy_write       = !rst && (wr_state_q == W_OPEN) && (wr_cnt_q < (BW+1)'(MAX_BEATS));
    assign rdy_finish      = !rst && (wr_state_q == W_OPEN);
    assign rdy_start_read  = !rst && (rd_state_q == R_IDLE);
    assign rdy_read        = !rst && (rd_state_q == R_OPEN);

    logic en_start_write, en_write, en_finish, en_inv, en_start_read, en_read;
    assign en_start_write = bus.EN_start_writing_prt_entry  && rdy_start_write;
    assign en_write       = bus.EN_write_prt_entry          && rdy_write;
    assign en_finish      = bus.EN_finish_writing_prt_entry && rdy_finish;
    assign en_inv         = bus.EN_invalidate_prt_entry     && !rst;
    assign en_start_read  = bus.EN_start_reading_prt_entry  && rdy_start_read;
    assign en_read        = bus.EN_read_prt_entry           && rdy_read;

    // A beat written alongside finish still counts toward the length
    logic [BW:0] wr_fill;
    logic        rd_last;
    logic [SW-1:0] sr_slot, inv_slot;
    assign wr_fill  = wr_cnt_q + (en_write ? (BW+1)'(1) : (BW+1)'(0));
    assign rd_last  = (rd_state_q == R_OPEN) && ({1'b0, rd_ptr_q} == (len_q[rd_slot_q] - (BW+1)'(1)));
    assign sr_slot  = bus.start_reading_prt_entry_slot;
    assign inv_slot = bus.invalidate_prt_entry_slot;

    assign bus.RDY_start_writing_prt_entry  = rdy_start_write;
    assign bus.start_writing_prt_entry      = alloc_idx;
    assign bus.RDY_write_prt_entry          = rdy_write;
    assign bus.RDY_finish_writing_prt_entry = rdy_finish;
    assign bus.RDY_invalidate_prt_entry     = !rst;
    assign bus.RDY_start_reading_prt_entry  = rdy_start_read;
    assign bus.RDY_read_prt_entry           = rdy_read;
    assign bus.read_prt_entry               = mem_q[{rd_slot_q, rd_ptr_q}];
    assign bus.read_prt_entry_last          = rd_last;
    assign bus.read_prt_entry_err           = err_q;
    assign bus.is_prt_slot_free             = any_free;
    assign bus.RDY_is_prt_slot_free         = !rst;

    // Packet storage: one write port from the open write, async read at the read pointer
    always_ff @(posedge clk) begin
        if (en_write) mem_q[{wr_slot_q, wr_cnt_q[BW-1:0]}] <= bus.write_prt_entry_data;
    end

    // Slot states plus write and read FSMs; invalidate is applied last so it wins same-cycle races
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= FREE;
                len_q[i]  <= '0;
            end
            wr_state_q <= W_IDLE;
            wr_slot_q  <= '0;
            wr_cnt_q   <= '0;
            rd_state_q <= R_IDLE;
            rd_slot_q  <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (en_start_write) begin
                slot_q[alloc_idx] <= WRITING;
                wr_slot_q         <= alloc_idx;
                wr_cnt_q          <= '0;
                wr_state_q        <= W_OPEN;
            end
            if (en_write) wr_cnt_q <= wr_cnt_q + (BW+1)'(1);
            if (en_finish) begin
                len_q[wr_slot_q]  <= wr_fill;
                slot_q[wr_slot_q] <= (wr_fill == '0) ? FREE : VALID;
                wr_state_q        <= W_IDLE;
            end
            if (en_start_read) begin
                if (slot_q[sr_slot] == VALID) begin
                    slot_q[sr_slot] <= READING;
                    rd_slot_q       <= sr_slot;
                    rd_ptr_q        <= '0;
                    rd_state_q      <= R_OPEN;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (en_read) begin
                rd_ptr_q <= rd_ptr_q + BW'(1);
                if (rd_last) begin
`ifdef PRT_AUTO_INVALIDATE_EN
                    slot_q[rd_slot_q] <= FREE;
`else
                    slot_q[rd_slot_q] <= VALID;
`endif
                    rd_state_q <= R_IDLE;
                end
            end
            if (en_inv && (slot_q[inv_slot] == VALID || slot_q[inv_slot] == READING)) begin
                slot_q[inv_slot] <= FREE;
                if (slot_q[inv_slot] == READING || (en_start_read && sr_slot == inv_slot))
                    rd_state_q <= R_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_prt_slot_store.sv
// tb/tb_prt_slot_store.sv - directed scoreboard bench for prt_slot_store
module tb_prt_slot_store;
    localparam int DW = 32;
    localparam int NS = 16;
    localparam int MB = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prt_slot_store_if #(.DATA_WIDTH(DW), .NUM_SLOTS(NS)) bus ();

    prt_slot_store #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .MAX_BEATS(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [DW:0] exp_q [$];
    logic [DW:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted read beat is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (!rst) begin
            if ((bus.EN_write_prt_entry && !bus.RDY_write_prt_entry) ||
                (bus.EN_read_prt_entry && !bus.RDY_read_prt_entry) ||
                (bus.EN_start_writing_prt_entry && !bus.RDY_start_writing_prt_entry) ||
                (bus.EN_start_reading_prt_entry && !bus.RDY_start_reading_prt_entry) ||
                (bus.EN_finish_writing_prt_entry && !bus.RDY_finish_writing_prt_entry)) begin
                checks++;
                errors++;
                $display("FAIL protocol: EN driven while RDY low at %0t", $time);
            end
            if (bus.EN_read_prt_entry && bus.RDY_read_prt_entry) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_beat: unexpected beat %0h", bus.read_prt_entry);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("read_beat{last,data}", {31'd0, bus.read_prt_entry_last, bus.read_prt_entry},
                        {31'd0, mon_e});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_write();
        bus.EN_start_writing_prt_entry = 1'b1;
        step();
        bus.EN_start_writing_prt_entry = 1'b0;
    endtask

    task automatic wbeat(input logic [DW-1:0] d);
        bus.EN_write_prt_entry   = 1'b1;
        bus.write_prt_entry_data = d;
        step();
        bus.EN_write_prt_entry   = 1'b0;
    endtask

    task automatic finish_write();
        bus.EN_finish_writing_prt_entry = 1'b1;
        step();
        bus.EN_finish_writing_prt_entry = 1'b0;
    endtask

    task automatic finish_with(input logic [DW-1:0] d);
        bus.EN_write_prt_entry          = 1'b1;
        bus.write_prt_entry_data        = d;
        bus.EN_finish_writing_prt_entry = 1'b1;
        step();
        bus.EN_write_prt_entry          = 1'b0;
        bus.EN_finish_writing_prt_entry = 1'b0;
    endtask

    task automatic inval(input int s);
        bus.EN_invalidate_prt_entry   = 1'b1;
        bus.invalidate_prt_entry_slot = 4'(s);
        step();
        bus.EN_invalidate_prt_entry   = 1'b0;
    endtask

    task automatic start_read(input int s);
        bus.EN_start_reading_prt_entry   = 1'b1;
        bus.start_reading_prt_entry_slot = 4'(s);
        step();
        bus.EN_start_reading_prt_entry   = 1'b0;
    endtask

    task automatic rbeat(input logic [DW-1:0] d, input logic l);
        exp_q.push_back({l, d});
        bus.EN_read_prt_entry = 1'b1;
        step();
        bus.EN_read_prt_entry = 1'b0;
    endtask

    task automatic write3(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        start_write();
        wbeat(d0);
        wbeat(d1);
        finish_with(d2);
    endtask

    int first_fill;
    int exp_alloc;

    initial begin
        bus.EN_start_writing_prt_entry   = 1'b0;
        bus.EN_write_prt_entry           = 1'b0;
        bus.write_prt_entry_data         = '0;
        bus.EN_finish_writing_prt_entry  = 1'b0;
        bus.EN_invalidate_prt_entry      = 1'b0;
        bus.invalidate_prt_entry_slot    = '0;
        bus.EN_start_reading_prt_entry   = 1'b0;
        bus.start_reading_prt_entry_slot = '0;
        bus.EN_read_prt_entry            = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy_start_write", bus.RDY_start_writing_prt_entry, 0);
        chk("rst_rdy_invalidate", bus.RDY_invalidate_prt_entry, 0);
        chk("rst_rdy_is_free", bus.RDY_is_prt_slot_free, 0);
        chk("rst_rdy_start_read", bus.RDY_start_reading_prt_entry, 0);
        rst = 1'b0;
        #1;
        chk("idle_rdy_start_write", bus.RDY_start_writing_prt_entry, 1);
        chk("idle_alloc", bus.start_writing_prt_entry, 0);
        chk("idle_is_free", bus.is_prt_slot_free, 1);
        chk("idle_rdy_invalidate", bus.RDY_invalidate_prt_entry, 1);
        chk("idle_rdy_write", bus.RDY_write_prt_entry, 0);
        chk("idle_rdy_read", bus.RDY_read_prt_entry, 0);
        chk("idle_err", bus.read_prt_entry_err, 0);

        // 1: three-beat packet into slot 0
        start_write();
        chk("t1_rdy_write", bus.RDY_write_prt_entry, 1);
        chk("t1_rdy_finish", bus.RDY_finish_writing_prt_entry, 1);
        chk("t1_rdy_start_write_open", bus.RDY_start_writing_prt_entry, 0);
        wbeat(32'hAAAA_0001);
        wbeat(32'hBBBB_0002);
        wbeat(32'hCCCC_0003);
        finish_write();
        chk("t1_next_alloc", bus.start_writing_prt_entry, 1);
        chk("t1_rdy_start_write", bus.RDY_start_writing_prt_entry, 1);

        // 2: stream slot 0 back
        start_read(0);
        chk("t2_rdy_read", bus.RDY_read_prt_entry, 1);
        chk("t2_rdy_start_read_busy", bus.RDY_start_reading_prt_entry, 0);
        rbeat(32'hAAAA_0001, 1'b0);
        rbeat(32'hBBBB_0002, 1'b0);
        rbeat(32'hCCCC_0003, 1'b1);
        chk("t2_rdy_read_done", bus.RDY_read_prt_entry, 0);
        chk("t2_rdy_start_read", bus.RDY_start_reading_prt_entry, 1);

        // 3: fill every slot, then free slot 5
`ifdef PRT_AUTO_INVALIDATE_EN
        first_fill = 0;
`else
        first_fill = 1;
`endif
        for (int k = first_fill; k < NS; k++) begin
            chk("t3_alloc_order", bus.start_writing_prt_entry, k);
            start_write();
            wbeat(32'h1000_0000 + k);
            finish_write();
        end
        chk("t3_full_rdy_start_write", bus.RDY_start_writing_prt_entry, 0);
        chk("t3_full_is_free", bus.is_prt_slot_free, 0);
        inval(5);
        chk("t3_alloc_after_inval", bus.start_writing_prt_entry, 5);
        chk("t3_rdy_start_write", bus.RDY_start_writing_prt_entry, 1);
        chk("t3_is_free", bus.is_prt_slot_free, 1);
        start_read(7);
        rbeat(32'h1000_0007, 1'b1);

        // 4: read request on a FREE slot
        start_read(5);
        chk("t4_err_pulse", bus.read_prt_entry_err, 1);
        chk("t4_rdy_read", bus.RDY_read_prt_entry, 0);
        step();
        chk("t4_err_clear", bus.read_prt_entry_err, 0);
        chk("t4_rdy_read_after", bus.RDY_read_prt_entry, 0);

        // 5: full-depth packet, then a zero-length packet
        start_write();
        for (int i = 0; i < MB - 1; i++) wbeat(32'h5000_0000 + i);
        chk("t5_rdy_write_63", bus.RDY_write_prt_entry, 1);
        wbeat(32'h5000_0000 + MB - 1);
        chk("t5_rdy_write_64", bus.RDY_write_prt_entry, 0);
        chk("t5_rdy_finish_64", bus.RDY_finish_writing_prt_entry, 1);
        finish_write();
        start_read(5);
        for (int i = 0; i < MB; i++) rbeat(32'h5000_0000 + i, (i == MB - 1));
`ifdef PRT_AUTO_INVALIDATE_EN
        exp_alloc = 5;
`else
        exp_alloc = 7;
`endif
        inval(7);
        chk("t5_alloc", bus.start_writing_prt_entry, exp_alloc);
        start_write();
        finish_write();
        chk("t5_zero_is_free", bus.is_prt_slot_free, 1);
        chk("t5_zero_alloc", bus.start_writing_prt_entry, exp_alloc);
        start_read(exp_alloc);
        chk("t5_zero_err", bus.read_prt_entry_err, 1);

        // 6: write+finish same cycle, full read, then abort after one beat
        write3(32'hD000_0001, 32'hD000_0002, 32'hD000_0003);
        start_read(exp_alloc);
        rbeat(32'hD000_0001, 1'b0);
        rbeat(32'hD000_0002, 1'b0);
        rbeat(32'hD000_0003, 1'b1);
`ifdef PRT_AUTO_INVALIDATE_EN
        chk("t6_auto_freed", bus.start_writing_prt_entry, exp_alloc);
        write3(32'hD000_0001, 32'hD000_0002, 32'hD000_0003);
`endif
        start_read(exp_alloc);
        rbeat(32'hD000_0001, 1'b0);
        inval(exp_alloc);
        chk("t6_abort_rdy_read", bus.RDY_read_prt_entry, 0);
        chk("t6_abort_rdy_start_read", bus.RDY_start_reading_prt_entry, 1);
        chk("t6_abort_alloc", bus.start_writing_prt_entry, exp_alloc);
        start_read(exp_alloc);
        chk("t6_abort_err", bus.read_prt_entry_err, 1);
`ifndef PRT_AUTO_INVALIDATE_EN
        start_read(0);
        rbeat(32'hAAAA_0001, 1'b0);
        rbeat(32'hBBBB_0002, 1'b0);
        rbeat(32'hCCCC_0003, 1'b1);
`endif

        repeat (4) step();
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
